// File: rtl/memory_writeback.sv
// Memory/writeback pipeline stage: word-addressed data memory, load/store, writeback registers.
// Define DMEM_WAIT_EN for multi-cycle accesses through an IDLE/WAIT/DONE FSM; otherwise single-cycle.
module memory_writeback #(
    parameter int unsigned DMEM_WORDS  = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_MemtoReg,
    input  logic        XM_RegWrite,
    input  logic        XM_MemRead,
    input  logic        XM_MemWrite,
    input  logic [31:0] XM_ALUout,
    input  logic [31:0] XM_MD,
    input  logic [4:0]  XM_RD,
    output logic        MW_MemtoReg,
    output logic        MW_RegWrite,
    output logic [4:0]  MW_RD,
    output logic [31:0] MDR,
    output logic [31:0] MW_ALUout,
    output logic        stall,
    output logic        misalign,
    input  logic [6:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int unsigned IW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] mem [DMEM_WORDS];

    // Operation being committed this cycle (live inputs or the latched access)
    logic          op_mtr;
    logic          op_rw;
    logic          op_mr;
    logic          op_mw;
    logic [31:0]   op_alu;
    logic [31:0]   op_md;
    logic [4:0]    op_rd;
    logic [IW-1:0] op_idx;
    logic          op_mis;
    logic          op_load;
    logic          op_store;
    logic          commit;

    assign dbg_data = mem[IW'(dbg_addr)];

`ifdef DMEM_WAIT_EN
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          lat_mtr;
    logic          lat_rw;
    logic          lat_mr;
    logic          lat_mw;
    logic [31:0]   lat_alu;
    logic [31:0]   lat_md;
    logic [4:0]    lat_rd;
    logic          mem_op;

    assign mem_op = XM_MemRead | XM_MemWrite;
    assign stall  = ((state == IDLE) && mem_op) || (state == WAIT);
    assign commit = ((state == IDLE) && !mem_op) || (state == DONE);

    assign op_mtr = (state == DONE) ? lat_mtr : XM_MemtoReg;
    assign op_rw  = (state == DONE) ? lat_rw  : XM_RegWrite;
    assign op_mr  = (state == DONE) ? lat_mr  : XM_MemRead;
    assign op_mw  = (state == DONE) ? lat_mw  : XM_MemWrite;
    assign op_alu = (state == DONE) ? lat_alu : XM_ALUout;
    assign op_md  = (state == DONE) ? lat_md  : XM_MD;
    assign op_rd  = (state == DONE) ? lat_rd  : XM_RD;
`else
    assign stall  = 1'b0;
    assign commit = 1'b1;

    assign op_mtr = XM_MemtoReg;
    assign op_rw  = XM_RegWrite;
    assign op_mr  = XM_MemRead;
    assign op_mw  = XM_MemWrite;
    assign op_alu = XM_ALUout;
    assign op_md  = XM_MD;
    assign op_rd  = XM_RD;
`endif

    // Address upper bits are dropped so accesses wrap around the memory
    assign op_idx   = op_alu[IW+1:2];
    assign op_mis   = (op_mr | op_mw) && (op_alu[1:0] != 2'b00);
    assign op_store = op_mw && !op_mis;
    assign op_load  = op_mr && !op_mw && !op_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            MW_MemtoReg <= 1'b0;
            MW_RegWrite <= 1'b0;
            MW_RD       <= 5'd0;
            MDR         <= 32'd0;
            MW_ALUout   <= 32'd0;
            misalign    <= 1'b0;
            for (int i = 0; i < int'(DMEM_WORDS); i++) begin
                mem[IW'(i)] <= 32'd0;
            end
`ifdef DMEM_WAIT_EN
            state   <= IDLE;
            cnt     <= '0;
            lat_mtr <= 1'b0;
            lat_rw  <= 1'b0;
            lat_mr  <= 1'b0;
            lat_mw  <= 1'b0;
            lat_alu <= 32'd0;
            lat_md  <= 32'd0;
            lat_rd  <= 5'd0;
`endif
        end else begin
`ifdef DMEM_WAIT_EN
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        lat_mtr     <= XM_MemtoReg;
                        lat_rw      <= XM_RegWrite;
                        lat_mr      <= XM_MemRead;
                        lat_mw      <= XM_MemWrite;
                        lat_alu     <= XM_ALUout;
                        lat_md      <= XM_MD;
                        lat_rd      <= XM_RD;
                        cnt         <= CW'(WAIT_CYCLES - 1);
                        MW_RegWrite <= 1'b0;
                        MW_MemtoReg <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    MW_RegWrite <= 1'b0;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
`endif
            // Writeback registers, store and load happen together on commit
            if (commit) begin
                MW_MemtoReg <= op_mtr;
                MW_RegWrite <= op_rw && !op_mw && !op_mis;
                MW_RD       <= op_rd;
                MW_ALUout   <= op_alu;
                MDR         <= op_load ? mem[op_idx] : 32'd0;
                if (op_store) begin
                    mem[op_idx] <= op_md;
                end
                if (op_mis) begin
                    misalign <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_writeback.sv
// Directed bench for memory_writeback: reset, pass-through, load/store, misalign, wrap, reset abort.
// Stall expectations follow DMEM_WAIT_EN when the bench is built with it.
module tb_memory_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        XM_MemtoReg;
    logic        XM_RegWrite;
    logic        XM_MemRead;
    logic        XM_MemWrite;
    logic [31:0] XM_ALUout;
    logic [31:0] XM_MD;
    logic [4:0]  XM_RD;
    logic        MW_MemtoReg;
    logic        MW_RegWrite;
    logic [4:0]  MW_RD;
    logic [31:0] MDR;
    logic [31:0] MW_ALUout;
    logic        stall;
    logic        misalign;
    logic [6:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_WAIT_EN
    localparam int MEM_STALLS = 3;
`else
    localparam int MEM_STALLS = 0;
`endif

    always #5 clk = ~clk;

    memory_writeback #(
        .DMEM_WORDS (128),
        .WAIT_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .XM_MemtoReg(XM_MemtoReg),
        .XM_RegWrite(XM_RegWrite),
        .XM_MemRead (XM_MemRead),
        .XM_MemWrite(XM_MemWrite),
        .XM_ALUout  (XM_ALUout),
        .XM_MD      (XM_MD),
        .XM_RD      (XM_RD),
        .MW_MemtoReg(MW_MemtoReg),
        .MW_RegWrite(MW_RegWrite),
        .MW_RD      (MW_RD),
        .MDR        (MDR),
        .MW_ALUout  (MW_ALUout),
        .stall      (stall),
        .misalign   (misalign),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    task automatic drive_nop();
        XM_MemtoReg = 1'b0;
        XM_RegWrite = 1'b0;
        XM_MemRead  = 1'b0;
        XM_MemWrite = 1'b0;
        XM_ALUout   = 32'd0;
        XM_MD       = 32'd0;
        XM_RD       = 5'd0;
    endtask

    // Present one instruction, hold it while stalled, return at the negedge after it commits
    task automatic issue(input logic mtr, input logic rw, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] md, input logic [4:0] rd,
                         output int stalls);
        bit done;
        XM_MemtoReg = mtr;
        XM_RegWrite = rw;
        XM_MemRead  = mr;
        XM_MemWrite = mw;
        XM_ALUout   = alu;
        XM_MD       = md;
        XM_RD       = rd;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (stall === 1'b1) stalls++;
            else done = 1'b1;
            @(posedge clk);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL issue_timeout: stall still high after %0d cycles, required to drop", stalls);
        end
        #1;
        drive_nop();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_nop();
        dbg_addr = 7'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (MW_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b required 0", MW_RegWrite); end
        checks++; if (MW_MemtoReg !== 1'b0) begin errors++; $display("FAIL reset_memtoreg: got %b required 0", MW_MemtoReg); end
        checks++; if (MW_RD !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d required 0", MW_RD); end
        checks++; if (MDR !== 32'd0) begin errors++; $display("FAIL reset_mdr: got %h required 0", MDR); end
        checks++; if (MW_ALUout !== 32'd0) begin errors++; $display("FAIL reset_aluout: got %h required 0", MW_ALUout); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b required 0", misalign); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", stall); end
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_mem0: got %h required 0", dbg_data); end
        dbg_addr = 7'd127;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_mem127: got %h required 0", dbg_data); end
    endtask

    task automatic test_rtype();
        int st;
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'd0, 5'd3, st);
        checks++; if (MW_ALUout !== 32'h1234_5678) begin errors++; $display("FAIL rtype_aluout: got %h required 12345678", MW_ALUout); end
        checks++; if (MW_RD !== 5'd3) begin errors++; $display("FAIL rtype_rd: got %0d required 3", MW_RD); end
        checks++; if (MDR !== 32'd0) begin errors++; $display("FAIL rtype_mdr: got %h required 0", MDR); end
        checks++; if (MW_RegWrite !== 1'b1) begin errors++; $display("FAIL rtype_regwrite: got %b required 1", MW_RegWrite); end
        checks++; if (st !== 0) begin errors++; $display("FAIL rtype_stall_cycles: got %0d required 0", st); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rtype_stall: got %b required 0", stall); end
    endtask

    task automatic test_store_load();
        int st;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, st);
        checks++; if (st !== MEM_STALLS) begin errors++; $display("FAIL store_stall_cycles: got %0d required %0d", st, MEM_STALLS); end
        checks++; if (MW_RegWrite !== 1'b0) begin errors++; $display("FAIL store_regwrite: got %b required 0", MW_RegWrite); end
        dbg_addr = 7'd4;
        #1;
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem4: got %h required deadbeef", dbg_data); end
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd8, st);
        checks++; if (st !== MEM_STALLS) begin errors++; $display("FAIL load_stall_cycles: got %0d required %0d", st, MEM_STALLS); end
        checks++; if (MDR !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_mdr: got %h required deadbeef", MDR); end
        checks++; if (MW_RD !== 5'd8) begin errors++; $display("FAIL load_rd: got %0d required 8", MW_RD); end
        checks++; if (MW_RegWrite !== 1'b1) begin errors++; $display("FAIL load_regwrite: got %b required 1", MW_RegWrite); end
        checks++; if (MW_MemtoReg !== 1'b1) begin errors++; $display("FAIL load_memtoreg: got %b required 1", MW_MemtoReg); end
        @(negedge clk);
        checks++; if (MW_RegWrite !== 1'b0) begin errors++; $display("FAIL load_regwrite_one_cycle: got %b required 0", MW_RegWrite); end
        checks++; if (MDR !== 32'd0) begin errors++; $display("FAIL load_mdr_after_nop: got %h required 0", MDR); end
    endtask

    task automatic test_misalign();
        int st;
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h13, 32'd0, 5'd5, st);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b required 1", misalign); end
        checks++; if (MW_RegWrite !== 1'b0) begin errors++; $display("FAIL misalign_regwrite: got %b required 0", MW_RegWrite); end
        checks++; if (MDR !== 32'd0) begin errors++; $display("FAIL misalign_mdr: got %h required 0", MDR); end
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 32'h1111_1111, 5'd0, st);
        dbg_addr = 7'd4;
        #1;
        checks++; if (dbg_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_store_suppressed: got %h required deadbeef", dbg_data); end
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'd0, 5'd2, st);
        checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %b required 1", misalign); end
        checks++; if (MW_RegWrite !== 1'b1) begin errors++; $display("FAIL misalign_next_rtype: got %b required 1", MW_RegWrite); end
    endtask

    task automatic test_wrap();
        int st;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hA5A5_A5A5, 5'd0, st);
        dbg_addr = 7'd0;
        #1;
        checks++; if (dbg_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wrap_mem0: got %h required a5a5a5a5", dbg_data); end
        dbg_addr = 7'd127;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL wrap_mem127: got %h required 0", dbg_data); end
        issue(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'd0, 5'd4, st);
        checks++; if (MDR !== 32'hA5A5_A5A5) begin errors++; $display("FAIL wrap_load_mdr: got %h required a5a5a5a5", MDR); end
    endtask

    task automatic test_read_write_both();
        int st;
        issue(1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 32'h77, 5'd9, st);
        dbg_addr = 7'd2;
        #1;
        checks++; if (dbg_data !== 32'h77) begin errors++; $display("FAIL rw_both_mem2: got %h required 77", dbg_data); end
        checks++; if (MDR !== 32'd0) begin errors++; $display("FAIL rw_both_mdr: got %h required 0", MDR); end
        checks++; if (MW_RegWrite !== 1'b0) begin errors++; $display("FAIL rw_both_regwrite: got %b required 0", MW_RegWrite); end
    endtask

    task automatic test_reset_abort();
        int st;
        XM_MemtoReg = 1'b0;
        XM_RegWrite = 1'b0;
        XM_MemRead  = 1'b0;
        XM_MemWrite = 1'b1;
        XM_ALUout   = 32'h04;
        XM_MD       = 32'h55;
        XM_RD       = 5'd0;
`ifdef DMEM_WAIT_EN
        @(posedge clk);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL abort_in_wait_stall: got %b required 1", stall); end
        @(negedge clk);
        rst = 1'b1;
`else
        rst = 1'b1;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_nop();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b required 0", stall); end
        checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL abort_misalign: got %b required 0", misalign); end
        dbg_addr = 7'd1;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL abort_mem1: got %h required 0", dbg_data); end
        dbg_addr = 7'd4;
        #1;
        checks++; if (dbg_data !== 32'd0) begin errors++; $display("FAIL abort_mem4_cleared: got %h required 0", dbg_data); end
        issue(1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0000, 32'd0, 5'd7, st);
        checks++; if (st !== 0) begin errors++; $display("FAIL abort_idle_stall_cycles: got %0d required 0", st); end
        checks++; if (MW_ALUout !== 32'hCAFE_0000) begin errors++; $display("FAIL abort_idle_aluout: got %h required cafe0000", MW_ALUout); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype();
        test_store_load();
        test_misalign();
        test_wrap();
        test_read_write_both();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_writeback.md
MEMORY_WRITEBACK -- requirements
Module: memory_writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst, and both SHALL appear first in the port list.
REQ-002 Parameter DMEM_WORDS, default 128, SHALL set the data memory depth in 32-bit words, and SHALL be a power of two.
REQ-003 Parameter WAIT_CYCLES, default 2, SHALL set the number of extra memory wait cycles; its legal range SHALL be 1..7.
REQ-004 Port clk, input, 1 bit: the clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, input, 1 bit each: control bits from the execute stage.
REQ-007 Port XM_ALUout, input, 32 bits: ALU result, used as the byte address for loads and stores.
REQ-008 Port XM_MD, input, 32 bits: store data.
REQ-009 Port XM_RD, input, 5 bits: destination register.
REQ-010 Port MW_MemtoReg, MW_RegWrite, output, 1 bit each: writeback controls to the register file.
REQ-011 Port MW_RD, output, 5 bits: writeback register index.
REQ-012 Port MDR, output, 32 bits: loaded data.
REQ-013 Port MW_ALUout, output, 32 bits: forwarded ALU result.
REQ-014 Port stall, output, 1 bit: freezes the upstream pipeline while high.
REQ-015 Port misalign, output, 1 bit: sticky misaligned-access flag.
REQ-016 Port dbg_addr, input, 7 bits, and dbg_data, output, 32 bits, SHALL form the switch-driven memory inspection port.

Function
REQ-017 The word index SHALL be XM_ALUout[log2(DMEM_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DMEM_WORDS*4.
REQ-018 An access SHALL be misaligned when XM_ALUout[1:0] != 0. On a misaligned access, the memory write SHALL be suppressed, MDR SHALL be 0, MW_RegWrite SHALL be 0, and misalign SHALL be set.
REQ-019 When XM_MemRead and XM_MemWrite are both 1, the access SHALL be a store only, and MDR SHALL be 0.
REQ-020 The FSM states SHALL be IDLE, WAIT and DONE.
REQ-021 IDLE: a non-memory instruction SHALL register the MW_* outputs one cycle later, with MDR = 0. A load or store SHALL go to WAIT, latch all XM_* inputs, and assert stall in the same cycle combinationally.
REQ-022 WAIT: an internal counter SHALL count from WAIT_CYCLES-1 down to 0. stall SHALL stay 1 and MW_RegWrite SHALL be held 0. At 0 the FSM SHALL go to DONE.
REQ-023 DONE: a store SHALL write memory once on the clock edge that leaves DONE. A load SHALL register MDR = mem[index]. The MW_* outputs SHALL be driven from the latched controls for exactly one cycle. stall SHALL be 0. The FSM SHALL return to IDLE.
REQ-024 XM_* inputs present while stall = 1 SHALL be ignored, because upstream holds them.
REQ-025 A load immediately after a store to the same word SHALL return the newly stored data.
REQ-026 dbg_data SHALL be combinational mem[dbg_addr modulo DMEM_WORDS] and SHALL have no effect on the FSM.
REQ-027 MW_RegWrite SHALL never be 1 for a store, a misaligned load, or while in WAIT.

Reset
REQ-028 When rst = 1 on a clock edge, the FSM SHALL go to IDLE, the counter to 0, and all MW_* outputs, MDR and misalign to 0, and stall SHALL read 0 in the following cycle.
REQ-029 Every data memory word SHALL be cleared to 0 on reset.
REQ-030 A reset arriving during WAIT or DONE SHALL abort the access, and any pending store SHALL not be written.

Configuration
REQ-031 Macro DMEM_WAIT_EN SHALL select the memory timing.
REQ-032 With DMEM_WAIT_EN defined, behaviour SHALL be as specified in REQ-020..REQ-024.
REQ-033 Without DMEM_WAIT_EN, WAIT and DONE SHALL be removed and stall SHALL be constant 0. Loads and stores SHALL complete from IDLE with one-cycle registered latency: a store writes on the same edge, and MDR is valid the next cycle. All other requirements SHALL still hold.

Verification
REQ-034 Store then load: store XM_MD=0xDEADBEEF at XM_ALUout=0x10, then load from 0x10 with XM_RD=8. The bench SHALL see MDR=0xDEADBEEF, MW_RD=8 and MW_RegWrite=1 for one cycle; with DMEM_WAIT_EN and WAIT_CYCLES=2, stall SHALL be high for 3 cycles per access.
REQ-035 R-type pass-through: XM_ALUout=0x12345678, XM_RegWrite=1, XM_RD=3. The next cycle SHALL show MW_ALUout=0x12345678, MW_RD=3, MDR=0 and stall=0.
REQ-036 Misaligned load at 0x13: misalign SHALL be 1 and stay 1, MW_RegWrite SHALL be 0, and memory SHALL be unchanged.
REQ-037 Wrap-around: store 0xA5A5A5A5 at 0x200 with DMEM_WORDS=128. dbg_addr=0 SHALL then show dbg_data=0xA5A5A5A5.
REQ-038 Reset during WAIT of a store of 0x55 to 0x04: the FSM SHALL be in IDLE the next cycle, and dbg_addr=1 SHALL show dbg_data=0.
REQ-039 Load with MemRead=MemWrite=1 at 0x08 with data 0x77: mem[2] SHALL equal 0x77, MDR SHALL be 0, and MW_RegWrite SHALL be 0.
